pulpino_boot_ctrl: RTL and testbench
====================================

PULPINO_BOOT_CTRL -- requirements
Module: pulpino_boot_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: core reset stretch length in cycles (range 2..255).
REQ-002 SHALL have parameter DEFAULT_BOOT_ADDR, default 32'h0000_8000: boot_addr_o value after reset.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port master_reset_i, input, 1 bit: JTAG-master reset request, active-high level, synchronous to clk_clk.
REQ-006 SHALL have port cmd_valid_i, input, 1 bit: one-cycle command strobe from the PIO bridge.
REQ-007 SHALL have port cmd_code_i, input, 2 bits: 0 CLR_ERR, 1 SET_ADDR, 2 START, 3 STOP.
REQ-008 SHALL have port cmd_addr_i, input, 32 bits: boot address operand for SET_ADDR.
REQ-009 SHALL have port core_rst_o, output, 1 bit: active-high reset to the PULPino core.
REQ-010 SHALL have port fetch_enable_o, output, 1 bit: drives the core's fetch_enable_i.
REQ-011 SHALL have port boot_addr_o, output, 32 bits: drives the core's boot_addr_i.
REQ-012 SHALL have port clock_gating_o, output, 1 bit: drives the core's clock_gating_i.
REQ-013 SHALL have port testmode_o, output, 1 bit: drives the core's testmode_i; tied to 0.
REQ-014 SHALL have port status_o, output, 32 bits: readback word for the PIO input.

Function
REQ-015 SHALL implement an FSM with states INIT=0, HALT=1, BOOT=2, RUN=3.
REQ-016 INIT and BOOT SHALL each assert core_rst_o for exactly RST_CYCLES cycles using an 8-bit down-counter.
REQ-017 When the counter expires, INIT SHALL go to HALT and BOOT SHALL go to RUN.
REQ-018 All outputs SHALL be registered; fetch_enable_o SHALL be 1 only in RUN.
REQ-019 clock_gating_o SHALL be 1 in HALT and 0 in all other states.
REQ-020 A command SHALL be sampled only on a cycle with cmd_valid_i=1; it takes effect one cycle after sampling.
REQ-021 SET_ADDR in HALT SHALL load boot_addr_o from cmd_addr_i; boot_addr_o SHALL be stable in all other states.
REQ-022 START in HALT SHALL enter BOOT, reload the counter and clear the run counter.
REQ-023 STOP in RUN SHALL enter HALT, deasserting fetch_enable_o on the next cycle.
REQ-024 SET_ADDR or START outside HALT, and STOP outside RUN, SHALL be ignored and SHALL set sticky err.
REQ-025 CLR_ERR SHALL clear err in any state.
REQ-026 master_reset_i=1 SHALL force INIT with the counter reloaded, regardless of state or any command in the same cycle; it does not clear err.
REQ-027 INIT SHALL hold while master_reset_i=1; counting starts on the first cycle after it deasserts.
REQ-028 A 24-bit run counter SHALL increment each cycle in RUN, saturate at 24'hFF_FFFF, and hold its value in other states.
REQ-029 status_o SHALL be: [1:0] state, [2] fetch_enable_o, [3] err, [7:4] 0, [31:8] run counter.

Reset
REQ-030 reset_reset SHALL asynchronously force the following values:
- state INIT, counter RST_CYCLES, core_rst_o 1
- fetch_enable_o 0, clock_gating_o 0, testmode_o 0
- boot_addr_o DEFAULT_BOOT_ADDR, err 0, run counter 0
REQ-031 Reset mid-BOOT or mid-RUN SHALL abandon the operation; the sequence restarts through INIT to HALT.

Structure
REQ-032 A shared package SHALL hold the state enum, the command-code constants, and the status bit-field positions.
REQ-033 The stretch counter SHALL be a sub-module, pulpino_rst_stretch (load, busy, done).
REQ-034 Expected size is 150-250 lines of RTL.

Verification
REQ-035 Reset release with RST_CYCLES=16 -> core_rst_o 1 for 16 cycles, then state HALT, clock_gating_o 1, boot_addr_o 32'h0000_8000.
REQ-036 In HALT, SET_ADDR 32'h0000_0080, then START -> 16 reset cycles, then RUN, fetch_enable_o 1, boot_addr_o 32'h0000_0080, status_o[31:8] counting from 0.
REQ-037 START while in RUN -> state unchanged, status_o[3]=1; then CLR_ERR -> status_o[3]=0.
REQ-038 master_reset_i high for 5 cycles during RUN, with STOP in the same first cycle -> INIT, fetch_enable_o 0; after release, 16 cycles to HALT; err unchanged.
REQ-039 Force the run counter to 24'hFF_FFFE and run 3 cycles -> it saturates at 24'hFF_FFFF; STOP -> HALT with the counter held.
REQ-040 reset_reset asserted mid-BOOT -> all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/pulpino_boot_ctrl_pkg.sv
// Shared definitions for the PULPino boot controller: FSM states,
// PIO command codes and the layout of the status readback word.
package pulpino_boot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HALT = 2'd1,
    ST_BOOT = 2'd2,
    ST_RUN  = 2'd3
  } boot_state_e;

  localparam logic [1:0] CMD_CLR_ERR  = 2'd0;
  localparam logic [1:0] CMD_SET_ADDR = 2'd1;
  localparam logic [1:0] CMD_START    = 2'd2;
  localparam logic [1:0] CMD_STOP     = 2'd3;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_STATE_MSB = 1;
  localparam int STAT_FETCH_BIT = 2;
  localparam int STAT_ERR_BIT   = 3;
  localparam int STAT_RUN_LSB   = 8;
  localparam int STAT_RUN_MSB   = 31;

  localparam int          RUN_CNT_W   = 24;
  localparam logic [23:0] RUN_CNT_MAX = 24'hFF_FFFF;

  // Saturating increment of the run counter.
  function automatic logic [RUN_CNT_W-1:0] run_cnt_inc(input logic [RUN_CNT_W-1:0] v);
    return (v == RUN_CNT_MAX) ? v : v + 24'd1;
  endfunction

endpackage

// File: rtl/pulpino_boot_ctrl_stretch.sv
// Core reset stretch counter: an 8-bit down-counter reloaded with CYCLES.
// o_done marks the last counted cycle so the owner can change state on it.
module pulpino_rst_stretch #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_busy,
  output logic o_done
);

  localparam logic [7:0] LP_LOAD = 8'(CYCLES);

  logic [7:0] r_cnt;

  // Reload on request, otherwise count down to zero while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= LP_LOAD;
    end else if (i_load) begin
      r_cnt <= LP_LOAD;
    end else if (i_en && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_busy = (r_cnt != 8'd0);
  assign o_done = i_en && (r_cnt == 8'd1);

endmodule

// File: rtl/pulpino_boot_ctrl.sv
// PULPino boot controller: sequences core reset, boot address and fetch
// enable under PIO commands, with a JTAG-master reset override.
module pulpino_boot_ctrl
  import pulpino_boot_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES        = 16,
  parameter logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_8000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        master_reset_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_code_i,
  input  logic [31:0] cmd_addr_i,
  output logic        core_rst_o,
  output logic        fetch_enable_o,
  output logic [31:0] boot_addr_o,
  output logic        clock_gating_o,
  output logic        testmode_o,
  output logic [31:0] status_o
);

  boot_state_e          r_state;
  logic                 r_core_rst;
  logic                 r_fetch_en;
  logic                 r_clk_gate;
  logic [31:0]          r_boot_addr;
  logic                 r_err;
  logic [RUN_CNT_W-1:0] r_run_cnt;

  logic w_cmd_clr;
  logic w_cmd_set;
  logic w_cmd_start;
  logic w_cmd_stop;
  logic w_cmd_bad;
  logic w_in_stretch;
  logic w_cnt_load;
  logic w_cnt_en;
  logic w_cnt_busy;
  logic w_cnt_done;
  logic [31:0] w_status;

  assign w_cmd_clr   = cmd_valid_i && (cmd_code_i == CMD_CLR_ERR);
  assign w_cmd_set   = cmd_valid_i && (cmd_code_i == CMD_SET_ADDR);
  assign w_cmd_start = cmd_valid_i && (cmd_code_i == CMD_START);
  assign w_cmd_stop  = cmd_valid_i && (cmd_code_i == CMD_STOP);

  // Commands that are not legal in the current state are dropped and flagged.
  assign w_cmd_bad = ((w_cmd_set || w_cmd_start) && (r_state != ST_HALT)) ||
                     (w_cmd_stop && (r_state != ST_RUN));

  // Master reset keeps the counter full so counting begins after release.
  assign w_in_stretch = (r_state == ST_INIT) || (r_state == ST_BOOT);
  assign w_cnt_load   = master_reset_i || ((r_state == ST_HALT) && w_cmd_start);
  assign w_cnt_en     = w_in_stretch && !master_reset_i && w_cnt_busy;

  pulpino_rst_stretch #(
    .CYCLES (RST_CYCLES)
  ) u_stretch (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_busy (w_cnt_busy),
    .o_done (w_cnt_done)
  );

  // Boot sequencing FSM with all core-facing outputs registered.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= ST_INIT;
      r_core_rst  <= 1'b1;
      r_fetch_en  <= 1'b0;
      r_clk_gate  <= 1'b0;
      r_boot_addr <= DEFAULT_BOOT_ADDR;
      r_err       <= 1'b0;
      r_run_cnt   <= '0;
    end else begin
      // Every cycle spent in RUN counts, including the one that leaves it.
      if (r_state == ST_RUN) begin
        r_run_cnt <= run_cnt_inc(r_run_cnt);
      end

      if (master_reset_i) begin
        // Override wins over any same-cycle command; err is left alone.
        r_state    <= ST_INIT;
        r_core_rst <= 1'b1;
        r_fetch_en <= 1'b0;
        r_clk_gate <= 1'b0;
      end else begin
        if (w_cmd_clr) begin
          r_err <= 1'b0;
        end else if (w_cmd_bad) begin
          r_err <= 1'b1;
        end

        case (r_state)
          ST_INIT: begin
            if (w_cnt_done) begin
              r_state    <= ST_HALT;
              r_core_rst <= 1'b0;
              r_clk_gate <= 1'b1;
            end
          end
          ST_HALT: begin
            if (w_cmd_set) begin
              r_boot_addr <= cmd_addr_i;
            end else if (w_cmd_start) begin
              r_state    <= ST_BOOT;
              r_core_rst <= 1'b1;
              r_clk_gate <= 1'b0;
              r_run_cnt  <= '0;
            end
          end
          ST_BOOT: begin
            if (w_cnt_done) begin
              r_state    <= ST_RUN;
              r_core_rst <= 1'b0;
              r_fetch_en <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_cmd_stop) begin
              r_state    <= ST_HALT;
              r_fetch_en <= 1'b0;
              r_clk_gate <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_INIT;
          end
        endcase
      end
    end
  end

  // Pack the status readback word from the registered state.
  always_comb begin
    w_status = '0;
    w_status[STAT_STATE_MSB:STAT_STATE_LSB] = r_state;
    w_status[STAT_FETCH_BIT]                = r_fetch_en;
    w_status[STAT_ERR_BIT]                  = r_err;
    w_status[STAT_RUN_MSB:STAT_RUN_LSB]     = r_run_cnt;
  end

  assign core_rst_o     = r_core_rst;
  assign fetch_enable_o = r_fetch_en;
  assign boot_addr_o    = r_boot_addr;
  assign clock_gating_o = r_clk_gate;
  assign testmode_o     = 1'b0;
  assign status_o       = w_status;

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Directed-vector bench for the PULPino boot controller (RST_CYCLES = 16).
module tb_pulpino_boot_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        master_reset_i;
  logic        cmd_valid_i;
  logic [1:0]  cmd_code_i;
  logic [31:0] cmd_addr_i;
  logic        core_rst_o;
  logic        fetch_enable_o;
  logic [31:0] boot_addr_o;
  logic        clock_gating_o;
  logic        testmode_o;
  logic [31:0] status_o;

  int n_vec = 0;
  int n_err = 0;

  pulpino_boot_ctrl dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .master_reset_i (master_reset_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_code_i     (cmd_code_i),
    .cmd_addr_i     (cmd_addr_i),
    .core_rst_o     (core_rst_o),
    .fetch_enable_o (fetch_enable_o),
    .boot_addr_o    (boot_addr_o),
    .clock_gating_o (clock_gating_o),
    .testmode_o     (testmode_o),
    .status_o       (status_o)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code, input logic [31:0] addr);
    cmd_valid_i = 1'b1;
    cmd_code_i  = code;
    cmd_addr_i  = addr;
    tick();
    cmd_valid_i = 1'b0;
    $display("cmd code=%0d addr=%h -> status=%h boot_addr=%h", code, addr, status_o, boot_addr_o);
  endtask

  function automatic logic [31:0] stat(input logic [1:0] st, input logic fe,
                                       input logic er, input logic [23:0] rc);
    return {rc, 4'b0000, er, fe, st};
  endfunction

  initial begin
    reset_reset    = 1'b1;
    master_reset_i = 1'b0;
    cmd_valid_i    = 1'b0;
    cmd_code_i     = 2'd0;
    cmd_addr_i     = 32'd0;
    #12;
    chk("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("rst_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("rst_gate", {31'd0, clock_gating_o}, 32'd0);
    chk("rst_testmode", {31'd0, testmode_o}, 32'd0);
    chk("rst_boot_addr", boot_addr_o, 32'h0000_8000);
    chk("rst_status", status_o, 32'd0);

    // Release reset: 16 cycles of core reset, then HALT.
    tick();
    reset_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_core_rst", {31'd0, core_rst_o}, 32'd1);
      tick();
    end
    chk("halt_core_rst", {31'd0, core_rst_o}, 32'd0);
    chk("halt_status", status_o, stat(2'd1, 1'b0, 1'b0, 24'd0));
    chk("halt_gate", {31'd0, clock_gating_o}, 32'd1);
    chk("halt_boot_addr", boot_addr_o, 32'h0000_8000);
    $display("reset released: status=%h", status_o);

    // SET_ADDR then START.
    send(2'd1, 32'h0000_0080);
    chk("set_addr", boot_addr_o, 32'h0000_0080);
    send(2'd2, 32'd0);
    chk("boot_status", status_o, stat(2'd2, 1'b0, 1'b0, 24'd0));
    chk("boot_gate", {31'd0, clock_gating_o}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("boot_core_rst", {31'd0, core_rst_o}, 32'd1);
      tick();
    end
    chk("run_status", status_o, stat(2'd3, 1'b1, 1'b0, 24'd0));
    chk("run_core_rst", {31'd0, core_rst_o}, 32'd0);
    chk("run_fetch", {31'd0, fetch_enable_o}, 32'd1);
    chk("run_boot_addr", boot_addr_o, 32'h0000_0080);
    tick();
    tick();
    chk("run_cnt_2", status_o, stat(2'd3, 1'b1, 1'b0, 24'd2));

    // Illegal commands in RUN set err; CLR_ERR clears it.
    send(2'd2, 32'd0);
    chk("start_in_run", status_o, stat(2'd3, 1'b1, 1'b1, 24'd3));
    send(2'd0, 32'd0);
    chk("clr_err", status_o, stat(2'd3, 1'b1, 1'b0, 24'd4));
    send(2'd1, 32'h0000_1234);
    chk("set_in_run", status_o, stat(2'd3, 1'b1, 1'b1, 24'd5));
    chk("set_in_run_addr", boot_addr_o, 32'h0000_0080);

    // Master reset for 5 cycles with a STOP in the first one.
    master_reset_i = 1'b1;
    send(2'd3, 32'd0);
    chk("mrst_status", status_o, stat(2'd0, 1'b0, 1'b1, 24'd6));
    chk("mrst_core_rst", {31'd0, core_rst_o}, 32'd1);
    repeat (4) tick();
    chk("mrst_hold", status_o, stat(2'd0, 1'b0, 1'b1, 24'd6));
    master_reset_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("mrst_core_rst_cnt", {31'd0, core_rst_o}, 32'd1);
      tick();
    end
    chk("mrst_halt", status_o, stat(2'd1, 1'b0, 1'b1, 24'd6));
    chk("mrst_halt_gate", {31'd0, clock_gating_o}, 32'd1);
    $display("master reset done: status=%h", status_o);

    // STOP outside RUN is an error.
    send(2'd0, 32'd0);
    chk("halt_clr", status_o, stat(2'd1, 1'b0, 1'b0, 24'd6));
    send(2'd3, 32'd0);
    chk("stop_in_halt", status_o, stat(2'd1, 1'b0, 1'b1, 24'd6));
    send(2'd0, 32'd0);

    // Run counter saturation.
    send(2'd2, 32'd0);
    chk("boot2_status", status_o, stat(2'd2, 1'b0, 1'b0, 24'd0));
    repeat (16) tick();
    chk("run2_status", status_o, stat(2'd3, 1'b1, 1'b0, 24'd0));
    force dut.r_run_cnt = 24'hFF_FFFE;
    tick();
    release dut.r_run_cnt;
    repeat (3) tick();
    chk("sat_status", status_o, stat(2'd3, 1'b1, 1'b0, 24'hFF_FFFF));
    tick();
    chk("sat_hold", status_o[31:8], 32'h00FF_FFFF);
    send(2'd3, 32'd0);
    chk("stop_status", status_o, stat(2'd1, 1'b0, 1'b0, 24'hFF_FFFF));
    chk("stop_fetch", {31'd0, fetch_enable_o}, 32'd0);
    repeat (3) tick();
    chk("halt_cnt_held", status_o, stat(2'd1, 1'b0, 1'b0, 24'hFF_FFFF));

    // Asynchronous reset in the middle of BOOT.
    send(2'd3, 32'd0);
    chk("err_before_arst", status_o, stat(2'd1, 1'b0, 1'b1, 24'hFF_FFFF));
    send(2'd2, 32'd0);
    chk("boot3_status", status_o, stat(2'd2, 1'b0, 1'b1, 24'd0));
    repeat (3) tick();
    reset_reset = 1'b1;
    #1;
    chk("arst_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("arst_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("arst_gate", {31'd0, clock_gating_o}, 32'd0);
    chk("arst_testmode", {31'd0, testmode_o}, 32'd0);
    chk("arst_boot_addr", boot_addr_o, 32'h0000_8000);
    chk("arst_status", status_o, 32'd0);
    tick();
    reset_reset = 1'b0;
    repeat (15) tick();
    chk("arst_core_rst_15", {31'd0, core_rst_o}, 32'd1);
    tick();
    chk("arst_halt", status_o, stat(2'd1, 1'b0, 1'b0, 24'd0));
    chk("arst_halt_core_rst", {31'd0, core_rst_o}, 32'd0);
    chk("arst_halt_addr", boot_addr_o, 32'h0000_8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
